// File: rtl/gate_vector_sequencer.sv
// Truth-table stimulus driver and checker for a 2-input gate: steps {a,b} through
// 00,01,10,11, samples the gate output at the end of each hold window, counts mismatches.
module gate_vector_sequencer #(
  parameter int HOLD_CYCLES = 20,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             sample;
  logic             last_vec;
  logic             exp_out;
  logic             miss;
  logic [2:0]       err_next;

  // The driven vector and its index are the same register pair.
  assign vec_idx  = {a, b};
  assign sample   = (state == DRIVE) && (cnt == CNT_LAST);
  assign last_vec = (vec_idx == 2'd3);

  always_comb begin
    exp_out = 1'b0;
    case (op_q)
      2'b00:   exp_out = a & b;
      2'b01:   exp_out = a | b;
      2'b10:   exp_out = a ^ b;
      default: exp_out = ~(a & b);
    endcase
  end

  assign miss     = sample && (dut_out != exp_out);
  assign err_next = (miss && (err_cnt != 3'd4)) ? err_cnt + 3'd1 : err_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   if (sample && last_vec) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      DRIVE:   busy = 1'b1;
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      cnt     <= '0;
      a       <= 1'b0;
      b       <= 1'b0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            err_cnt <= '0;
            pass    <= 1'b0;
            cnt     <= '0;
            a       <= 1'b0;
            b       <= 1'b0;
          end
        end
        DRIVE: begin
          err_cnt <= err_next;
          if (sample) begin
            cnt <= '0;
            // pass is decided from err_next so a miss on the final vector counts.
            if (last_vec) pass <= (err_next == 3'd0);
            else          {a, b} <= vec_idx + 2'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          cnt <= '0;
          a   <= 1'b0;
          b   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Scoreboard bench: two sequencers (hold 4 and hold 1) share stimulus; a behavioural
// gate model feeds each, and a negedge monitor checks against per-sweep expectations.
module tb_gate_vector_sequencer;

  localparam int H0 = 4;
  localparam int H1 = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [1:0] a_s, b_s, busy_s, done_s, pass_s, dout_s;
  logic [2:0] err_s [2];
  logic [1:0] vidx_s [2];

  int         gate_mode;
  logic [1:0] gate_op;
  bit         glitch;
  bit         mon_en;

  bit         act [2];
  int         t [2];
  int         last_err [2];
  bit         last_pass [2];
  int         exp_q [2][$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gate_vector_sequencer #(.HOLD_CYCLES(H0), .CNT_W(5)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .dut_out(dout_s[0]),
    .a(a_s[0]), .b(b_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_cnt(err_s[0]), .vec_idx(vidx_s[0]));

  gate_vector_sequencer #(.HOLD_CYCLES(H1), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .dut_out(dout_s[1]),
    .a(a_s[1]), .b(b_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_cnt(err_s[1]), .vec_idx(vidx_s[1]));

  function automatic int hold(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  // Truth value of the selected function for vector v = {a,b}.
  function automatic bit fexp(input logic [1:0] o, input int v);
    case (o)
      2'd0:    return v == 3;
      2'd1:    return v != 0;
      2'd2:    return (v == 1) || (v == 2);
      default: return v != 3;
    endcase
  endfunction

  // Gate under test: 0 correct for gate_op, 1 always AND, 2 stuck at 0, 3 stuck at 1.
  function automatic bit gate(input int m, input logic [1:0] go, input int v);
    case (m)
      0:       return fexp(go, v);
      1:       return v == 3;
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int count_err(input int m, input logic [1:0] go, input logic [1:0] o);
    int n = 0;
    for (int v = 0; v < 4; v++) if (gate(m, go, v) != fexp(o, v)) n++;
    return n;
  endfunction

  // Optional glitch corrupts the gate output everywhere except the last cycle of a hold window.
  assign dout_s[0] = gate(gate_mode, gate_op, int'({a_s[0], b_s[0]}))
                     ^ (glitch && act[0] && ((t[0] % H0) != H0 - 1));
  assign dout_s[1] = gate(gate_mode, gate_op, int'({a_s[1], b_s[1]}))
                     ^ (glitch && act[1] && ((t[1] % H1) != H1 - 1));

  // Reference sweep tracker: t counts cycles since the accepted start edge, 0..4*H.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i]       <= 1'b0;
        t[i]         <= 0;
        last_err[i]  <= 0;
        last_pass[i] <= 1'b0;
        exp_q[i].delete();
      end else if (!act[i]) begin
        if (start) begin
          act[i] <= 1'b1;
          t[i]   <= 0;
          exp_q[i].push_back(count_err(gate_mode, gate_op, op));
        end
      end else if (t[i] == 4 * hold(i)) begin
        act[i]       <= 1'b0;
        last_err[i]  <= exp_q[i][0];
        last_pass[i] <= (exp_q[i][0] == 0);
        exp_q[i].pop_front();
      end else begin
        t[i] <= t[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input int i, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0d got=%0h want=%0h at %0t", name, i, t[i], got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (act[i] && t[i] < 4 * hold(i)) begin
          chk("busy_drive", i, 8'(busy_s[i]), 8'd1);
          chk("done_drive", i, 8'(done_s[i]), 8'd0);
          chk("vector", i, 8'({a_s[i], b_s[i]}), 8'(t[i] / hold(i)));
          chk("vec_idx", i, 8'(vidx_s[i]), 8'(t[i] / hold(i)));
          chk("pass_cleared", i, 8'(pass_s[i]), 8'd0);
        end else if (act[i]) begin
          chk("done_pulse", i, 8'(done_s[i]), 8'd1);
          chk("busy_finish", i, 8'(busy_s[i]), 8'd0);
          chk("expect_pending", i, 8'(exp_q[i].size() != 0), 8'd1);
          if (exp_q[i].size() != 0) begin
            chk("err_cnt_done", i, 8'(err_s[i]), 8'(exp_q[i][0]));
            chk("pass_done", i, 8'(pass_s[i]), 8'(exp_q[i][0] == 0));
          end
        end else begin
          chk("busy_idle", i, 8'(busy_s[i]), 8'd0);
          chk("done_idle", i, 8'(done_s[i]), 8'd0);
          chk("ab_idle", i, 8'({a_s[i], b_s[i], vidx_s[i]}), 8'd0);
          chk("err_cnt_held", i, 8'(err_s[i]), 8'(last_err[i]));
          chk("pass_held", i, 8'(pass_s[i]), 8'(last_pass[i]));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (act[0] || act[1]) begin
      @(negedge clk);
      if (++n > 500) begin
        $display("FAIL wait_idle timeout");
        $fatal(1);
      end
    end
  endtask

  task automatic wait_t(input int target);
    int n = 0;
    while (!(act[0] && t[0] == target)) begin
      @(negedge clk);
      if (++n > 500) begin
        $display("FAIL wait_t timeout target=%0d", target);
        $fatal(1);
      end
    end
  endtask

  // d: 0 plain, 1 extra start and op churn mid-sweep, 2 reset (with start) mid-sweep.
  task automatic run_sweep(input logic [1:0] o, input int m, input bit g, input int d);
    wait_idle();
    op = o; gate_op = o; gate_mode = m; glitch = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (d == 1) begin
      wait_t(2 * H0);
      start = 1'b1;
      op = ~o;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
        op = 2'($urandom_range(0, 3));
        @(negedge clk);
      end
    end else if (d == 2) begin
      wait_t(2 * H0 + 1);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
    end
    wait_idle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0;
    gate_mode = 0; gate_op = '0; glitch = 1'b0; mon_en = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_sweep(2'd0, 0, 1'b0, 0);
    run_sweep(2'd1, 1, 1'b0, 0);
    run_sweep(2'd3, 2, 1'b0, 0);
    run_sweep(2'd2, 0, 1'b0, 1);
    run_sweep(2'd1, 0, 1'b0, 2);
    run_sweep(2'd0, 0, 1'b0, 0);
    run_sweep(2'd2, 0, 1'b1, 0);
    run_sweep(2'd3, 3, 1'b1, 0);
    for (int k = 0; k < 12; k++)
      run_sweep(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
- Clocked stimulus/checker stage that sits directly upstream of a 2-input gate under test.
- Drives the gate's inputs `a`/`b` through the full truth table in order 00, 01, 10, 11, holding each vector for a programmable number of cycles.
- Samples the gate output at the end of each hold window and compares it against the expected value for a selected operation.
- Counts mismatches and reports done/pass; replaces hand-written `#delay` stimulus with synthesizable sequencing.

Parameters:
- HOLD_CYCLES, 20, cycles each vector is held; legal range 1..2^CNT_W-1.
- CNT_W, 5, width of the hold counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to run one full truth-table sweep.
- op  input  2  expected function: 00 AND, 01 OR, 10 XOR, 11 NAND.
- dut_out  input  1  output of the gate under test.
- a  output  1  gate input A (registered).
- b  output  1  gate input B (registered).
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when the last sweep had zero mismatches; held until the next start.
- err_cnt  output  3  mismatch count of the current or last sweep; range 0..4.
- vec_idx  output  2  index of the vector currently driven; equals {a,b}.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, vec_idx=0, hold counter=0.
  - Reset applies mid-sweep as well: the sweep is aborted and no done pulse is produced.
- States: IDLE, DRIVE, FINISH.
- IDLE:
  - a=b=0.
  - When start=1, the next edge does all of the following:
    - latch op into op_q;
    - clear err_cnt and pass;
    - set vec_idx=0, a=0, b=0, cnt=0, busy=1;
    - go to DRIVE.
- DRIVE:
  - cnt increments by 1 each cycle.
  - In the cycle where cnt==HOLD_CYCLES-1 (the sample cycle), dut_out is compared with exp = f(op_q, a, b).
    - On mismatch, err_cnt increments at that edge; it cannot exceed 4.
  - At the sample-cycle edge:
    - If vec_idx<3: vec_idx+1, {a,b}=vec_idx+1, cnt=0, stay in DRIVE.
    - If vec_idx==3: go to FINISH, keep a/b unchanged.
- FINISH (exactly one cycle):
  - done=1, busy=0.
  - pass=1 iff the final err_cnt==0, including any mismatch recorded on the last sample.
  - Next edge goes to IDLE, with a=b=0 and vec_idx=0.
- Timing:
  - Each vector is on a/b for exactly HOLD_CYCLES cycles.
  - start sampled at edge E0 → done high in the cycle after edge E0+4*HOLD_CYCLES.
  - Sweep latency from the start edge to the done edge is 4*HOLD_CYCLES+1 cycles.
- Boundary rules:
  - start while busy or in FINISH is ignored.
  - op changes during a sweep are ignored; op_q is used throughout.
  - HOLD_CYCLES=1: every cycle in DRIVE is a sample cycle.
  - dut_out is assumed settled combinationally within one cycle of an a/b change. It is sampled only in the sample cycle; glitches at other times are ignored.
  - err_cnt and pass persist after done until the next accepted start or reset.
  - rst and start asserted in the same cycle: rst wins, state stays IDLE.

Test Plan:
- HOLD_CYCLES=4, op=00, dut_out=a&b:
  - a/b step 00,01,10,11 every 4 cycles;
  - done pulses 17 cycles after the start edge;
  - err_cnt=0, pass=1.
- op=01 (OR) with dut_out=a&b → mismatches at vectors 01 and 10; err_cnt=2, pass=0 at done.
- op=11 (NAND) with dut_out stuck at 0 → mismatches at 00, 01, 10; err_cnt=3, pass=0.
- op=10 (XOR), correct DUT, with start pulsed again at vector 2 and op toggled mid-sweep → second start ignored; a single done pulse; pass=1.
- Assert rst during vector 2 → next cycle a=b=0, busy=0, err_cnt=0, no done pulse; a new start then completes normally with pass=1.
- HOLD_CYCLES=1, op=00, correct DUT → vectors change every cycle; done 5 cycles after the start edge; pass=1.
